// File: rtl/button_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : button_event_pkg
//  Purpose   : Shared state encoding and default timing constants for the
//              button event decoder.
//  Contents  : state_t   - decoder FSM states (IDLE / PRESS / HOLD)
//              DEFAULT_* - default parameter values for the decoder top
//  Revision  : 1.0 - initial release
// ============================================================================
package button_event_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEFAULT_LONG_TICKS   = 8;
   localparam int DEFAULT_REPEAT_TICKS = 4;
   localparam int DEFAULT_CNT_W        = 8;

endpackage : button_event_pkg
`default_nettype wire

// File: rtl/button_event_decoder_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module    : edge_detect
//  Purpose   : Registers one sample of a synchronous level and flags rising
//              and falling transitions between consecutive clk samples.
//  Ports     : clk  - system clock (rising edge)
//              rst  - asynchronous active-high reset, clears the history
//              d    - level to watch (already in the clk domain)
//              rise - high while d = 1 and the previous sample was 0
//              fall - high while d = 0 and the previous sample was 1
//  Revision  : 1.0 - initial release
// ============================================================================
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic d_q;

   // History clears to 0, so a level already high at reset release is
   // reported as a fresh rising edge on the first clk edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;
   assign fall = ~d & d_q;

endmodule : edge_detect
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module    : button_event_decoder
//  Purpose   : Turns a debounced button level into press / release /
//              long-press / auto-repeat pulses plus a held level. Timing is
//              counted in ticks of a divided clock sampled as data.
//  Ports     : clk          - system clock (rising edge)
//              rst          - asynchronous active-high reset
//              clock_div_i  - divided clock, sampled as data; 0->1 = tick
//              in_i         - debounced button level, 1 = pressed
//              press_o      - one-clk pulse on press
//              release_o    - one-clk pulse on release
//              long_press_o - one-clk pulse when a press becomes long
//              repeat_o     - one-clk auto-repeat pulse while held
//              held_o       - level, high while in HOLD
//  Revision  : 1.0 - initial release
// ============================================================================
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
   parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS,
   parameter int CNT_W        = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic clock_div_i,
   input  logic in_i,
   output logic press_o,
   output logic release_o,
   output logic long_press_o,
   output logic repeat_o,
   output logic held_o
);

   localparam logic [CNT_W-1:0] c_long_ticks   = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] c_repeat_ticks = CNT_W'(REPEAT_TICKS);
   localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

   logic w_in_rise;
   logic w_in_fall;
   logic w_tick;
   logic w_div_fall_unused;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_press_q, long_press_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   edge_detect u_in_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (in_i),
      .rise (w_in_rise),
      .fall (w_in_fall)
   );

   edge_detect u_div_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (clock_div_i),
      .rise (w_tick),
      .fall (w_div_fall_unused)
   );

   assign w_cnt_inc = cnt_q + c_one;

   // Next-state / output decode. Every output is computed here and then
   // registered, so each pulse appears on the edge that samples its cause.
   // Release is tested before the tick so that a simultaneous release
   // suppresses long_press / repeat and clears the counter.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_press_d = 1'b0;
      repeat_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // Ticks are ignored here; the counter is held at zero.
            cnt_d = '0;
            if (w_in_rise) begin
               press_d = 1'b1;
               state_d = PRESS;
            end
         end

         PRESS: begin
            if (w_in_fall) begin
               release_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (w_tick) begin
               if (w_cnt_inc == c_long_ticks) begin
                  long_press_d = 1'b1;
                  cnt_d        = '0;
                  state_d      = HOLD;
               end else begin
                  cnt_d = w_cnt_inc;
               end
            end
         end

         HOLD: begin
            if (w_in_fall) begin
               release_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (w_tick) begin
               if (w_cnt_inc == c_repeat_ticks) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = w_cnt_inc;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Registered copy of the upcoming state, so held tracks HOLD exactly.
      held_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_press_q <= 1'b0;
         repeat_q     <= 1'b0;
         held_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         press_q      <= press_d;
         release_q    <= release_d;
         long_press_q <= long_press_d;
         repeat_q     <= repeat_d;
         held_q       <= held_d;
      end
   end

   assign press_o      = press_q;
   assign release_o    = release_q;
   assign long_press_o = long_press_q;
   assign repeat_o     = repeat_q;
   assign held_o       = held_q;

endmodule : button_event_decoder
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module    : tb_button_event_decoder
//  Purpose   : Directed self-checking bench for button_event_decoder with
//              LONG_TICKS = 4, REPEAT_TICKS = 2 and a clock_div period of
//              10 clk (low for 5, high for 5).
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

   logic clk;
   logic rst;
   logic clock_div;
   logic in_b;
   logic press;
   logic rel;
   logic lp;
   logic rep;
   logic held;

   int phase;
   int n_cmp;
   int n_err;

   button_event_decoder #(
      .LONG_TICKS   (4),
      .REPEAT_TICKS (2),
      .CNT_W        (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clock_div_i  (clock_div),
      .in_i         (in_b),
      .press_o      (press),
      .release_o    (rel),
      .long_press_o (lp),
      .repeat_o     (rep),
      .held_o       (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse outputs must be mutually exclusive in every cycle.
   always @(negedge clk) begin
      n_cmp = n_cmp + 1;
      if ($countones({press, rel, lp, rep}) > 1) begin
         n_err = n_err + 1;
         $display("FAIL mutex t=%0t got press/rel/long/rep=%b%b%b%b required at most one high",
                  $time, press, rel, lp, rep);
      end
   end

   // One clk edge; afterwards advance clock_div for the next edge.
   // Edge k of a scenario samples phase (k-1)%10, so ticks land on k = 6, 16, ...
   task automatic step();
      @(posedge clk);
      #1;
      phase     = (phase == 9) ? 0 : phase + 1;
      clock_div = (phase >= 5);
   endtask

   task automatic align();
      while (phase != 0) step();
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst  = 1'b1;
      in_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         obs = {press, rel, lp, rep, held};
         n_cmp = n_cmp + 1;
         if (obs !== 5'b00000 || dut.cnt_q !== 8'd0) begin
            n_err = n_err + 1;
            $display("FAIL reset_hold k=%0d got=%b cnt=%0d required=00000 cnt=0", k, obs, dut.cnt_q);
         end
      end
      // Release reset with the button already pressed: press on the first edge.
      rst = 1'b0;
      step();
      obs = {press, rel, lp, rep, held};
      n_cmp = n_cmp + 1;
      if (obs !== 5'b10000) begin
         n_err = n_err + 1;
         $display("FAIL reset_release_press got=%b required=10000", obs);
      end
      step();
      obs = {press, rel, lp, rep, held};
      n_cmp = n_cmp + 1;
      if (obs !== 5'b00000) begin
         n_err = n_err + 1;
         $display("FAIL reset_press_width got=%b required=00000", obs);
      end
      in_b = 1'b0;
      step();
      obs = {press, rel, lp, rep, held};
      n_cmp = n_cmp + 1;
      if (obs !== 5'b01000) begin
         n_err = n_err + 1;
         $display("FAIL reset_then_release got=%b required=01000", obs);
      end
      repeat (2) step();
   endtask

   task automatic test_short_press();
      logic [4:0] obs, exp;
      align();
      for (int k = 1; k <= 40; k++) begin
         in_b = (k <= 25);
         step();
         obs = {press, rel, lp, rep, held};
         exp = {k == 1, k == 26, 1'b0, 1'b0, 1'b0};
         n_cmp = n_cmp + 1;
         if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL short_press k=%0d got=%b required=%b", k, obs, exp);
         end
      end
   endtask

   task automatic test_long_hold();
      logic [4:0] obs, exp;
      align();
      for (int k = 1; k <= 110; k++) begin
         in_b = (k <= 100);
         step();
         obs = {press, rel, lp, rep, held};
         exp = {k == 1, k == 101, k == 36, (k == 56 || k == 76 || k == 96),
                (k >= 36 && k <= 100)};
         n_cmp = n_cmp + 1;
         if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL long_hold k=%0d got=%b required=%b", k, obs, exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] obs, exp;
      align();
      // Edge 36 carries both the 4th tick and the falling edge of in.
      for (int k = 1; k <= 40; k++) begin
         in_b = (k <= 35);
         step();
         obs = {press, rel, lp, rep, held};
         exp = {k == 1, k == 36, 1'b0, 1'b0, 1'b0};
         n_cmp = n_cmp + 1;
         if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL simultaneous k=%0d got=%b required=%b", k, obs, exp);
         end
      end
      n_cmp = n_cmp + 1;
      if (dut.cnt_q !== 8'd0) begin
         n_err = n_err + 1;
         $display("FAIL simultaneous_cnt got=%0d required=0", dut.cnt_q);
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [4:0] obs, exp;
      align();
      for (int k = 1; k <= 45; k++) begin
         in_b = 1'b1;
         step();
         obs = {press, rel, lp, rep, held};
         exp = {k == 1, 1'b0, k == 36, 1'b0, k >= 36};
         n_cmp = n_cmp + 1;
         if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL mid_hold_setup k=%0d got=%b required=%b", k, obs, exp);
         end
      end
      // Asynchronous reset between edges clears outputs immediately.
      rst = 1'b1;
      #1;
      obs = {press, rel, lp, rep, held};
      n_cmp = n_cmp + 1;
      if (obs !== 5'b00000) begin
         n_err = n_err + 1;
         $display("FAIL mid_hold_async_rst got=%b required=00000", obs);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         obs = {press, rel, lp, rep, held};
         n_cmp = n_cmp + 1;
         if (obs !== 5'b00000) begin
            n_err = n_err + 1;
            $display("FAIL mid_hold_in_rst k=%0d got=%b required=00000", k, obs);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         in_b = (k <= 2);
         step();
         obs = {press, rel, lp, rep, held};
         exp = {k == 1, k == 3, 1'b0, 1'b0, 1'b0};
         n_cmp = n_cmp + 1;
         if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL mid_hold_after k=%0d got=%b required=%b", k, obs, exp);
         end
      end
   endtask

   task automatic test_idle_ticks();
      logic [4:0] obs;
      in_b = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         step();
         obs = {press, rel, lp, rep, held};
         n_cmp = n_cmp + 1;
         if (obs !== 5'b00000 || dut.cnt_q !== 8'd0) begin
            n_err = n_err + 1;
            $display("FAIL idle_ticks k=%0d got=%b cnt=%0d required=00000 cnt=0", k, obs, dut.cnt_q);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] obs, exp;
      align();
      for (int k = 1; k <= 8; k++) begin
         in_b = (k <= 3 || k == 5);
         step();
         obs = {press, rel, lp, rep, held};
         exp = {(k == 1 || k == 5), (k == 4 || k == 6), 1'b0, 1'b0, 1'b0};
         n_cmp = n_cmp + 1;
         if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL back_to_back k=%0d got=%b required=%b", k, obs, exp);
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      phase     = 0;
      clock_div = 1'b0;
      in_b      = 1'b0;
      rst       = 1'b1;
      test_reset();
      test_short_press();
      test_long_hold();
      test_simultaneous();
      test_reset_mid_hold();
      test_idle_ticks();
      test_back_to_back();
      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_button_event_decoder
`default_nettype wire

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_TICKS, default 8: number of clock_div ticks a press must persist before it counts as a long press; legal range 1..255.
REQ-002 Parameter REPEAT_TICKS, default 4: number of clock_div ticks between auto-repeat pulses while held; legal range 1..255.
REQ-003 Parameter CNT_W, default 8: tick counter width; SHALL satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port clock_div, input, 1: divided clock from clock_divider, sampled as data in the clk domain, never used as a clock.
REQ-008 Port in, input, 1: debounced button level from debouncer; 1 = pressed.
REQ-009 Port press, output, 1: one-clk pulse on press.
REQ-010 Port release, output, 1: one-clk pulse on release.
REQ-011 Port long_press, output, 1: one-clk pulse when a press becomes long.
REQ-012 Port repeat, output, 1: one-clk auto-repeat pulse while held.
REQ-013 Port held, output, 1: level; high while in state HOLD.

Function
REQ-014 A tick SHALL be one clk cycle in which clock_div is sampled 1 after being sampled 0 on the previous clk edge.
REQ-015 The FSM SHALL have exactly three states: IDLE, PRESS and HOLD.
REQ-016 IDLE: on a sampled 0->1 transition of in, the block SHALL assert press for one cycle, clear the counter and go to PRESS.
REQ-017 PRESS: each tick SHALL increment the counter. The tick that brings the count to LONG_TICKS SHALL assert long_press for one cycle, clear the counter and go to HOLD.
REQ-018 HOLD: held = 1. Each tick SHALL increment the counter. The tick that brings the count to REPEAT_TICKS SHALL assert repeat for one cycle and clear the counter.
REQ-019 In PRESS or HOLD, a sampled 1->0 transition of in SHALL assert release for one cycle, clear the counter and go to IDLE.
REQ-020 If a release and a tick occur in the same cycle, release wins: no long_press or repeat pulse, and the counter clears.
REQ-021 All outputs SHALL be registered. Each pulse SHALL be visible exactly one clk cycle after the clk edge at which its cause was sampled.
REQ-022 press, release, long_press and repeat SHALL each last exactly one clk cycle. At most one of them SHALL be high in any cycle.
REQ-023 Ticks in IDLE SHALL be ignored and the counter SHALL stay 0.
REQ-024 The counter SHALL never exceed max(LONG_TICKS, REPEAT_TICKS) and SHALL never wrap.

Reset
REQ-025 While rst = 1: state = IDLE, counter = 0, both edge-history registers = 0, and every output = 0, regardless of clk.
REQ-026 Reset asserted mid-press SHALL produce no release pulse.
REQ-027 If in = 1 when rst deasserts, a press pulse SHALL follow on the first clk edge after deassertion, because the history register holds 0.

Structure
REQ-028 Package button_event_pkg SHALL hold the state encoding (IDLE = 2'd0, PRESS = 2'd1, HOLD = 2'd2) and the default LONG_TICKS and REPEAT_TICKS constants.
REQ-029 Sub-module edge_detect (clk, rst, d, rise, fall) SHALL be instantiated twice: once for in and once for clock_div.

Verification
(All scenarios: LONG_TICKS = 4, REPEAT_TICKS = 2, clock_div period = 10 clk.)
REQ-030 Short press: in high for 25 clk -> exactly one press pulse and one release pulse; no long_press or repeat; held never high.
REQ-031 Long hold: in high for 100 clk -> press, then long_press on the 4th tick, then repeat on every 2nd tick after it; held high from long_press until release; release pulse ends it.
REQ-032 Simultaneous event: in falls in the same cycle as the 4th tick -> release pulse only; no long_press.
REQ-033 Reset mid-hold: rst pulsed while in HOLD -> all outputs 0 within the reset; no release pulse; a press pulse follows if in is still 1 after reset.
REQ-034 Idle ticks: in = 0 for 200 clk with clock_div running -> all outputs stay 0 and the counter stays 0.
REQ-035 Mutual exclusion: across all scenarios, at most one pulse output is high in any cycle; check with a monitor.
